// File: rtl/fmap_collector_pkg.sv
// Shared CNN constants for the feature-map collector: default geometry and FSM encoding.
package fmap_collector_pkg;

  localparam int CNN_DATA_WIDTH  = 8;
  localparam int CNN_IMG_WIDTH   = 28;
  localparam int CNN_NUM_FILTERS = 32;
  localparam int CNN_OUT_W       = CNN_IMG_WIDTH - 2;
  localparam int CNN_PLANE       = CNN_OUT_W * CNN_OUT_W;
  localparam int CNN_DEPTH       = CNN_NUM_FILTERS * CNN_PLANE;

  typedef logic [0:0] fmap_state_t;
  localparam fmap_state_t ST_FILL = 1'b0;
  localparam fmap_state_t ST_FULL = 1'b1;

endpackage

// File: rtl/fmap_collector_ram.sv
// Simple dual-port feature-map store: one write port, one registered read port, array not reset.
module fmap_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 18,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_collector.sv
// Collects filter-fastest conv samples into a channel-major frame buffer and serves reads once full.
module fmap_collector
  import fmap_collector_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int IMG_WIDTH   = CNN_IMG_WIDTH,
  parameter int NUM_FILTERS = CNN_NUM_FILTERS,
  localparam int OUT_W      = IMG_WIDTH - 2,
  localparam int PLANE      = OUT_W * OUT_W,
  localparam int DEPTH      = NUM_FILTERS * PLANE,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  input  logic                         frame_release,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_valid,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         frame_done,
  output logic                         frame_ready,
  output logic                         overrun
);

  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  fmap_state_t           state;
  logic [FW-1:0]         f_idx;
  logic [ADDR_WIDTH-1:0] pix_idx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_oob;
  logic                  addr_in_range;
  logic                  we;
  logic                  re;
  logic signed [DATA_WIDTH-1:0] ram_q;

  assign addr_in_range = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(DEPTH));
  assign we = (state == ST_FILL) && valid_in;
  assign re = (state == ST_FULL) && rd_en && addr_in_range;

  // Out-of-range reads still return a valid beat, but with zero data.
  assign rd_data = (rd_valid && !rd_oob) ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_FILL;
      f_idx       <= '0;
      pix_idx     <= '0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_oob      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_valid   <= (state == ST_FULL) && rd_en;
      rd_oob     <= !addr_in_range;
      case (state)
        ST_FILL: begin
          if (valid_in) begin
            if (f_idx == FW'(NUM_FILTERS - 1)) begin
              f_idx <= '0;
              if (pix_idx == ADDR_WIDTH'(PLANE - 1)) begin
                state       <= ST_FULL;
                frame_done  <= 1'b1;
                frame_ready <= 1'b1;
                pix_idx     <= '0;
                wr_addr     <= '0;
              end else begin
                pix_idx <= pix_idx + 1'b1;
                wr_addr <= pix_idx + 1'b1;
              end
            end else begin
              // Stepping by one plane per filter avoids an f*PLANE multiply.
              f_idx   <= f_idx + 1'b1;
              wr_addr <= wr_addr + ADDR_WIDTH'(PLANE);
            end
          end
        end
        default: begin
          if (valid_in) overrun <= 1'b1;
          if (frame_release) begin
            state       <= ST_FILL;
            frame_ready <= 1'b0;
            f_idx       <= '0;
            pix_idx     <= '0;
            wr_addr     <= '0;
          end
        end
      endcase
    end
  end

  fmap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr),
    .wdata (pixel_in),
    .re    (re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_fmap_collector.sv
// Scoreboard bench for fmap_collector with a 5x5 image and two filters (3x3 planes, 18 entries).
module tb_fmap_collector;

  localparam int DW    = 8;
  localparam int IMG   = 5;
  localparam int NF    = 2;
  localparam int OW    = IMG - 2;
  localparam int PL    = OW * OW;
  localparam int DEP   = NF * PL;
  localparam int AW    = $clog2(DEP);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          frame_release = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          frame_done;
  logic          frame_ready;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_mem [DEP];
  logic [DW-1:0] exp_q [$];
  int  m_f = 0, m_pix = 0;
  bit  m_full = 1'b0;
  bit  m_overrun = 1'b0;
  int  exp_done = 0;
  int  done_cnt = 0;

  fmap_collector #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (IMG),
    .NUM_FILTERS (NF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .pixel_in      (pixel_in),
    .frame_release (frame_release),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .frame_done    (frame_done),
    .frame_ready   (frame_ready),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
      else check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_f = 0; m_pix = 0; m_full = 1'b0; m_overrun = 1'b0;
    check("rst_done",    32'(frame_done),  32'd0);
    check("rst_ready",   32'(frame_ready), 32'd0);
    check("rst_overrun", 32'(overrun),     32'd0);
    check("rst_rdvalid", 32'(rd_valid),    32'd0);
    check("rst_rddata",  32'(rd_data),     32'd0);
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit completes;
    completes = 1'b0;
    valid_in = 1'b1;
    pixel_in = v;
    if (!m_full) begin
      exp_mem[m_f * PL + m_pix] = v;
      if (m_f == NF - 1 && m_pix == PL - 1) completes = 1'b1;
      if (m_f == NF - 1) begin m_f = 0; m_pix++; end
      else m_f++;
    end else begin
      m_overrun = 1'b1;
    end
    if (!m_full && !completes) check("done_early", 32'(frame_done), 32'd0);
    tick();
    valid_in = 1'b0;
    if (completes) begin
      m_full = 1'b1; m_f = 0; m_pix = 0; exp_done++;
      check("done_pulse", 32'(frame_done),  32'd1);
      check("ready_rise", 32'(frame_ready), 32'd1);
      tick();
      check("done_once",  32'(frame_done),  32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
    if (m_full) begin m_full = 1'b0; m_f = 0; m_pix = 0; end
  endtask

  task automatic rd(input int a, input bit with_release);
    rd_en = 1'b1;
    rd_addr = AW'(a);
    frame_release = with_release;
    if (m_full) exp_q.push_back((a < DEP) ? exp_mem[a] : '0);
    tick();
    rd_en = 1'b0;
    frame_release = 1'b0;
    if (with_release && m_full) begin m_full = 1'b0; m_f = 0; m_pix = 0; end
  endtask

  task automatic rd_all();
    for (int a = 0; a < DEP; a++) rd(a, 1'b0);
    idle(2);
    check("rd_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    do_reset();

    // read while filling is ignored
    rd(3, 1'b0);
    check("fill_rd_valid", 32'(rd_valid), 32'd0);

    // back-to-back frame 0..17
    for (int k = 0; k < DEP; k++) send(DW'(k));
    check("addr1_is_2", 32'(exp_mem[1]), 32'd2);
    rd_all();
    rd(20, 1'b0);
    idle(1);
    check("oob_drained", 32'(exp_q.size()), 32'd0);

    // sample while full: dropped, sticky overrun
    send(8'h55);
    check("overrun_set", 32'(overrun), 32'(m_overrun));
    rd_all();
    release_frame();
    check("ready_drop", 32'(frame_ready), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // gapped frame
    do_reset();
    for (int k = 0; k < DEP; k++) begin send(DW'(k)); idle(1); end
    rd_all();

    // release ignored in FILL, partial frame abandoned on reset
    do_reset();
    for (int k = 0; k < 7; k++) send(DW'(k));
    release_frame();
    do_reset();
    for (int k = 0; k < DEP; k++) send(DW'(100 + k));
    check("model_a0",  32'(exp_mem[0]), 32'd100);
    check("model_a9",  32'(exp_mem[9]), 32'd101);
    rd(0, 1'b0);
    rd(9, 1'b0);
    rd_all();

    // read and release together: read served, then release
    rd(5, 1'b1);
    idle(1);
    check("rel_ready", 32'(frame_ready), 32'd0);
    check("rel_drained", 32'(exp_q.size()), 32'd0);
    rd(4, 1'b0);

    // second frame of negative values
    for (int k = 1; k <= DEP; k++) send(DW'(-k));
    check("neg_model", 32'(exp_mem[0]), 32'hFF);
    rd(0, 1'b0);
    rd_all();
    check("no_overrun", 32'(overrun), 32'(m_overrun));

    // sample plus release together: release taken, sample dropped
    valid_in = 1'b1; pixel_in = 8'h33; frame_release = 1'b1;
    tick();
    valid_in = 1'b0; frame_release = 1'b0;
    m_full = 1'b0; m_overrun = 1'b1;
    check("vr_overrun", 32'(overrun), 32'd1);
    check("vr_ready",   32'(frame_ready), 32'd0);

    idle(2);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
